// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU, LSU and memory-port handshake bundle around mem_arbiter
interface mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_resp_data;
  logic        ifu_resp_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_write;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [31:0] lsu_resp_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_write;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
           lsu_req_valid, lsu_req_addr, lsu_req_write, lsu_req_wdata, lsu_req_wstrb, lsu_resp_ready,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
           lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
           mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wstrb
  );
  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
           lsu_req_valid, lsu_req_addr, lsu_req_write, lsu_req_wdata, lsu_req_wstrb, lsu_resp_ready,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
           lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
           mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: IFU/LSU arbiter and sequencer for one memory port; define MEM_ARB_RR_EN for round-robin grants
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata;
  logic          owner_lsu;
  logic          pick_lsu;
  logic          accept;
  logic          timeout;
  logic          done;
  logic          taken;
`ifdef MEM_ARB_RR_EN
  logic last_lsu;
  always_ff @(posedge clk)
    if (rst) last_lsu <= 1'b0;
    else if (accept) last_lsu <= pick_lsu;
  assign pick_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || !last_lsu);
`else
  assign pick_lsu = bus.lsu_req_valid;
`endif
  assign accept  = state == IDLE && (bus.ifu_req_valid || bus.lsu_req_valid);
  assign timeout = (state == REQ || state == WAIT) && cnt == TMAX;
  assign done    = timeout || (state == WAIT && bus.mem_resp_valid);
  assign taken   = owner_lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready;
  assign bus.ifu_req_ready  = accept && !pick_lsu;
  assign bus.lsu_req_ready  = accept && pick_lsu;
  assign bus.ifu_resp_data  = rdata;
  assign bus.lsu_resp_rdata = rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      rdata              <= '0;
      owner_lsu          <= 1'b0;
      bus.mem_req_valid  <= 1'b0;
      bus.mem_req_addr   <= '0;
      bus.mem_req_write  <= 1'b0;
      bus.mem_req_wdata  <= '0;
      bus.mem_req_wstrb  <= '0;
      bus.ifu_resp_valid <= 1'b0;
      bus.lsu_resp_valid <= 1'b0;
      bus.ifu_resp_err   <= 1'b0;
      bus.lsu_resp_err   <= 1'b0;
    end else if (accept) begin
      state             <= REQ;
      cnt               <= '0;
      owner_lsu         <= pick_lsu;
      bus.mem_req_valid <= 1'b1;
      bus.mem_req_addr  <= pick_lsu ? bus.lsu_req_addr : bus.ifu_req_addr;
      bus.mem_req_write <= pick_lsu && bus.lsu_req_write;
      bus.mem_req_wdata <= pick_lsu ? bus.lsu_req_wdata : '0;
      bus.mem_req_wstrb <= pick_lsu ? bus.lsu_req_wstrb : '0;
    end else if (done) begin
      // a timeout in REQ abandons the request, so mem_req_valid drops here too
      state              <= RESP;
      bus.mem_req_valid  <= 1'b0;
      rdata              <= (timeout || bus.mem_req_write) ? '0 : bus.mem_resp_rdata;
      bus.ifu_resp_valid <= !owner_lsu;
      bus.lsu_resp_valid <= owner_lsu;
      bus.ifu_resp_err   <= timeout && !owner_lsu;
      bus.lsu_resp_err   <= timeout && owner_lsu;
    end else if (state == REQ || state == WAIT) begin
      cnt <= cnt + 1'b1;
      if (state == REQ && bus.mem_req_ready) begin
        state             <= WAIT;
        bus.mem_req_valid <= 1'b0;
      end
    end else if (state == RESP && taken) begin
      state              <= IDLE;
      bus.ifu_resp_valid <= 1'b0;
      bus.lsu_resp_valid <= 1'b0;
      bus.ifu_resp_err   <= 1'b0;
      bus.lsu_resp_err   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grants, sequencing, backpressure, timeout and reset of mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  mem_arbiter_if a();
  mem_arbiter_if b();
  mem_arbiter #(.TIMEOUT(255)) dut_a (.clk(clk), .rst(rst), .bus(a));
  mem_arbiter #(.TIMEOUT(4)) dut_b (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic init_inputs();
    a.ifu_req_valid = 0; a.ifu_req_addr = 0; a.ifu_resp_ready = 0;
    a.lsu_req_valid = 0; a.lsu_req_addr = 0; a.lsu_req_write = 0; a.lsu_req_wdata = 0; a.lsu_req_wstrb = 0; a.lsu_resp_ready = 0;
    a.mem_req_ready = 0; a.mem_resp_valid = 0; a.mem_resp_rdata = 0;
    b.ifu_req_valid = 0; b.ifu_req_addr = 0; b.ifu_resp_ready = 0;
    b.lsu_req_valid = 0; b.lsu_req_addr = 0; b.lsu_req_write = 0; b.lsu_req_wdata = 0; b.lsu_req_wstrb = 0; b.lsu_resp_ready = 0;
    b.mem_req_ready = 0; b.mem_resp_valid = 0; b.mem_resp_rdata = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    cyc();
    cyc();
    #1;
    tests++; if ({a.ifu_req_ready, a.lsu_req_ready} !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b exp 00", {a.ifu_req_ready, a.lsu_req_ready}); end
    tests++; if ({a.ifu_resp_valid, a.lsu_resp_valid, a.ifu_resp_err, a.lsu_resp_err} !== 4'b0000) begin fails++; $display("FAIL reset_resp got %b exp 0000", {a.ifu_resp_valid, a.lsu_resp_valid, a.ifu_resp_err, a.lsu_resp_err}); end
    tests++; if (a.mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_req_valid got %b exp 0", a.mem_req_valid); end
    tests++; if ({a.mem_req_addr, a.mem_req_wdata, a.mem_req_wstrb, a.mem_req_write} !== 69'h0) begin fails++; $display("FAIL reset_mem_fields got %h exp 0", {a.mem_req_addr, a.mem_req_wdata, a.mem_req_wstrb, a.mem_req_write}); end
    tests++; if ({a.ifu_resp_data, a.lsu_resp_rdata} !== 64'h0) begin fails++; $display("FAIL reset_resp_data got %h exp 0", {a.ifu_resp_data, a.lsu_resp_rdata}); end
    tests++; if ({b.mem_req_valid, b.lsu_resp_valid, b.lsu_resp_err} !== 3'b000) begin fails++; $display("FAIL reset_b got %b exp 000", {b.mem_req_valid, b.lsu_resp_valid, b.lsu_resp_err}); end
    rst = 0;
  endtask
  task automatic test_ifu_fetch();
    cyc(); a.ifu_req_valid = 1; a.ifu_req_addr = 32'h8000_0000; a.mem_req_ready = 1; a.ifu_resp_ready = 1; #1;
    tests++; if ({a.ifu_req_ready, a.lsu_req_ready, a.mem_req_valid} !== 3'b100) begin fails++; $display("FAIL fetch_accept got %b exp 100", {a.ifu_req_ready, a.lsu_req_ready, a.mem_req_valid}); end
    cyc(); a.ifu_req_valid = 0; a.ifu_req_addr = 32'h1234_5678; #1;
    tests++; if ({a.mem_req_valid, a.mem_req_addr, a.mem_req_write, a.mem_req_wstrb} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0}) begin fails++; $display("FAIL fetch_req got %h exp %h", {a.mem_req_valid, a.mem_req_addr, a.mem_req_write, a.mem_req_wstrb}, {1'b1, 32'h8000_0000, 1'b0, 4'h0}); end
    cyc(); a.mem_resp_valid = 1; a.mem_resp_rdata = 32'h0000_0413; #1;
    tests++; if ({a.mem_req_valid, a.ifu_resp_valid} !== 2'b00) begin fails++; $display("FAIL fetch_wait got %b exp 00", {a.mem_req_valid, a.ifu_resp_valid}); end
    cyc(); a.mem_resp_valid = 0; #1;
    tests++; if ({a.ifu_resp_valid, a.ifu_resp_err, a.lsu_resp_valid} !== 3'b100) begin fails++; $display("FAIL fetch_resp got %b exp 100", {a.ifu_resp_valid, a.ifu_resp_err, a.lsu_resp_valid}); end
    tests++; if (a.ifu_resp_data !== 32'h0000_0413) begin fails++; $display("FAIL fetch_data got %h exp 00000413", a.ifu_resp_data); end
    cyc(); #1;
    tests++; if (a.ifu_resp_valid !== 1'b0) begin fails++; $display("FAIL fetch_done got %b exp 0", a.ifu_resp_valid); end
    a.ifu_resp_ready = 0; a.mem_req_ready = 0;
  endtask
  task automatic test_arbitration();
    logic exp_lsu;
    a.lsu_req_addr = 32'h100; a.lsu_req_write = 0; a.ifu_req_addr = 32'h200;
    a.mem_req_ready = 1; a.ifu_resp_ready = 1; a.lsu_resp_ready = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_lsu = (i % 2) == 0;
`else
      exp_lsu = 1'b1;
`endif
      cyc(); a.lsu_req_valid = 1; a.ifu_req_valid = 1; #1;
      tests++; if ({a.lsu_req_ready, a.ifu_req_ready} !== {exp_lsu, !exp_lsu}) begin fails++; $display("FAIL arb_grant[%0d] got %b exp %b", i, {a.lsu_req_ready, a.ifu_req_ready}, {exp_lsu, !exp_lsu}); end
      cyc(); #1;
      tests++; if (a.mem_req_addr !== (exp_lsu ? 32'h100 : 32'h200)) begin fails++; $display("FAIL arb_addr[%0d] got %h exp %h", i, a.mem_req_addr, exp_lsu ? 32'h100 : 32'h200); end
      cyc(); a.mem_resp_valid = 1; a.mem_resp_rdata = 32'hA0 + i; #1;
      cyc(); a.mem_resp_valid = 0; #1;
      tests++; if ({a.lsu_resp_valid, a.ifu_resp_valid} !== {exp_lsu, !exp_lsu}) begin fails++; $display("FAIL arb_resp[%0d] got %b exp %b", i, {a.lsu_resp_valid, a.ifu_resp_valid}, {exp_lsu, !exp_lsu}); end
      tests++; if ((exp_lsu ? a.lsu_resp_rdata : a.ifu_resp_data) !== 32'hA0 + i) begin fails++; $display("FAIL arb_data[%0d] got %h exp %h", i, exp_lsu ? a.lsu_resp_rdata : a.ifu_resp_data, 32'hA0 + i); end
    end
    a.lsu_req_valid = 0; a.ifu_req_valid = 0;
  endtask
  task automatic test_store_stall();
    cyc();
    a.lsu_req_valid = 1; a.lsu_req_addr = 32'h8000_1000; a.lsu_req_write = 1; a.lsu_req_wdata = 32'hDEAD_BEEF; a.lsu_req_wstrb = 4'h3;
    a.mem_req_ready = 0; a.lsu_resp_ready = 1; a.ifu_resp_ready = 1; #1;
    tests++; if ({a.lsu_req_ready, a.ifu_req_ready} !== 2'b10) begin fails++; $display("FAIL store_accept got %b exp 10", {a.lsu_req_ready, a.ifu_req_ready}); end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 1) begin a.lsu_req_valid = 0; a.lsu_req_addr = 0; a.lsu_req_write = 0; a.lsu_req_wdata = 0; a.lsu_req_wstrb = 4'hF; end
      a.mem_req_ready = i == 4; #1;
      tests++; if ({a.mem_req_valid, a.mem_req_addr, a.mem_req_write, a.mem_req_wdata, a.mem_req_wstrb} !== {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3}) begin fails++; $display("FAIL store_fields[%0d] got %h exp %h", i, {a.mem_req_valid, a.mem_req_addr, a.mem_req_write, a.mem_req_wdata, a.mem_req_wstrb}, {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'h3}); end
    end
    cyc(); a.mem_req_ready = 0; a.mem_resp_valid = 1; a.mem_resp_rdata = 32'hFFFF_FFFF; #1;
    tests++; if (a.mem_req_valid !== 1'b0) begin fails++; $display("FAIL store_req_drop got %b exp 0", a.mem_req_valid); end
    cyc(); a.mem_resp_valid = 0; #1;
    tests++; if ({a.lsu_resp_valid, a.lsu_resp_err, a.ifu_resp_valid} !== 3'b100) begin fails++; $display("FAIL store_resp got %b exp 100", {a.lsu_resp_valid, a.lsu_resp_err, a.ifu_resp_valid}); end
    tests++; if (a.lsu_resp_rdata !== 32'h0) begin fails++; $display("FAIL store_rdata got %h exp 0", a.lsu_resp_rdata); end
    cyc(); #1;
    tests++; if (a.lsu_resp_valid !== 1'b0) begin fails++; $display("FAIL store_done got %b exp 0", a.lsu_resp_valid); end
    a.lsu_resp_ready = 0; a.ifu_resp_ready = 0;
  endtask
  task automatic test_timeout();
    cyc(); b.lsu_req_valid = 1; b.lsu_req_addr = 32'h40; b.lsu_req_write = 0; b.mem_req_ready = 1; b.lsu_resp_ready = 0; #1;
    tests++; if (b.lsu_req_ready !== 1'b1) begin fails++; $display("FAIL to_accept got %b exp 1", b.lsu_req_ready); end
    cyc(); b.lsu_req_valid = 0; #1;
    tests++; if (b.mem_req_valid !== 1'b1) begin fails++; $display("FAIL to_req got %b exp 1", b.mem_req_valid); end
    for (int i = 2; i <= 5; i++) begin
      cyc(); #1;
      tests++; if (b.lsu_resp_valid !== 1'b0) begin fails++; $display("FAIL to_early[%0d] got %b exp 0", i, b.lsu_resp_valid); end
    end
    cyc(); #1;
    tests++; if ({b.lsu_resp_valid, b.lsu_resp_err, b.ifu_resp_valid, b.ifu_resp_err} !== 4'b1100) begin fails++; $display("FAIL to_err got %b exp 1100", {b.lsu_resp_valid, b.lsu_resp_err, b.ifu_resp_valid, b.ifu_resp_err}); end
    tests++; if (b.lsu_resp_rdata !== 32'h0) begin fails++; $display("FAIL to_rdata got %h exp 0", b.lsu_resp_rdata); end
    b.lsu_resp_ready = 1;
    cyc(); b.lsu_resp_ready = 0; #1;
    tests++; if ({b.lsu_resp_valid, b.lsu_resp_err} !== 2'b00) begin fails++; $display("FAIL to_clear got %b exp 00", {b.lsu_resp_valid, b.lsu_resp_err}); end
    cyc(); b.mem_resp_valid = 1; b.mem_resp_rdata = 32'h0000_0BAD; #1;
    cyc(); b.mem_resp_valid = 0; #1;
    tests++; if ({b.lsu_resp_valid, b.ifu_resp_valid, b.mem_req_valid} !== 3'b000) begin fails++; $display("FAIL to_late_ignored got %b exp 000", {b.lsu_resp_valid, b.ifu_resp_valid, b.mem_req_valid}); end
    cyc(); b.lsu_req_valid = 1; b.lsu_req_addr = 32'h44; b.lsu_resp_ready = 1; #1;
    tests++; if (b.lsu_req_ready !== 1'b1) begin fails++; $display("FAIL to_next_accept got %b exp 1", b.lsu_req_ready); end
    cyc(); b.lsu_req_valid = 0; #1;
    tests++; if ({b.mem_req_valid, b.mem_req_addr} !== {1'b1, 32'h44}) begin fails++; $display("FAIL to_next_req got %h exp %h", {b.mem_req_valid, b.mem_req_addr}, {1'b1, 32'h44}); end
    cyc(); b.mem_resp_valid = 1; b.mem_resp_rdata = 32'h55AA; #1;
    cyc(); b.mem_resp_valid = 0; #1;
    tests++; if ({b.lsu_resp_valid, b.lsu_resp_err, b.lsu_resp_rdata} !== {1'b1, 1'b0, 32'h55AA}) begin fails++; $display("FAIL to_next_resp got %h exp %h", {b.lsu_resp_valid, b.lsu_resp_err, b.lsu_resp_rdata}, {1'b1, 1'b0, 32'h55AA}); end
    cyc(); #1;
    tests++; if (b.lsu_resp_valid !== 1'b0) begin fails++; $display("FAIL to_next_done got %b exp 0", b.lsu_resp_valid); end
    b.lsu_resp_ready = 0; b.mem_req_ready = 0;
  endtask
  task automatic test_backpressure();
    cyc(); a.ifu_req_valid = 1; a.ifu_req_addr = 32'h8000_0004; a.mem_req_ready = 1; a.ifu_resp_ready = 0; a.lsu_resp_ready = 1; #1;
    tests++; if (a.ifu_req_ready !== 1'b1) begin fails++; $display("FAIL bp_accept got %b exp 1", a.ifu_req_ready); end
    cyc(); a.ifu_req_valid = 0; #1;
    cyc(); a.mem_resp_valid = 1; a.mem_resp_rdata = 32'hCAFE_F00D; #1;
    for (int i = 3; i <= 8; i++) begin
      cyc();
      a.mem_resp_valid = i == 4; a.mem_resp_rdata = 32'h1111_1111;
      a.lsu_req_valid = 1; a.lsu_req_addr = 32'h300; a.lsu_req_write = 0; a.ifu_resp_ready = i == 8; #1;
      tests++; if ({a.ifu_resp_valid, a.ifu_resp_data, a.ifu_req_ready, a.lsu_req_ready} !== {1'b1, 32'hCAFE_F00D, 2'b00}) begin fails++; $display("FAIL bp_hold[%0d] got %h exp %h", i, {a.ifu_resp_valid, a.ifu_resp_data, a.ifu_req_ready, a.lsu_req_ready}, {1'b1, 32'hCAFE_F00D, 2'b00}); end
    end
    cyc(); a.ifu_resp_ready = 0; #1;
    tests++; if ({a.ifu_resp_valid, a.lsu_req_ready} !== 2'b01) begin fails++; $display("FAIL bp_idle got %b exp 01", {a.ifu_resp_valid, a.lsu_req_ready}); end
    cyc(); a.lsu_req_valid = 0; #1;
    tests++; if ({a.mem_req_valid, a.mem_req_addr} !== {1'b1, 32'h300}) begin fails++; $display("FAIL bp_next_req got %h exp %h", {a.mem_req_valid, a.mem_req_addr}, {1'b1, 32'h300}); end
    cyc(); a.mem_resp_valid = 1; a.mem_resp_rdata = 32'h77; #1;
    cyc(); a.mem_resp_valid = 0; #1;
    tests++; if ({a.lsu_resp_valid, a.lsu_resp_rdata} !== {1'b1, 32'h77}) begin fails++; $display("FAIL bp_next_resp got %h exp %h", {a.lsu_resp_valid, a.lsu_resp_rdata}, {1'b1, 32'h77}); end
    cyc(); a.lsu_resp_ready = 0; a.mem_req_ready = 0; #1;
  endtask
  task automatic test_reset_mid();
    cyc(); a.ifu_req_valid = 1; a.ifu_req_addr = 32'h10; a.mem_req_ready = 1; a.ifu_resp_ready = 1; #1;
    cyc(); a.ifu_req_valid = 0; #1;
    tests++; if (a.mem_req_valid !== 1'b1) begin fails++; $display("FAIL rm_req got %b exp 1", a.mem_req_valid); end
    cyc(); rst = 1; #1;
    cyc(); rst = 0; a.mem_resp_valid = 1; a.mem_resp_rdata = 32'hDEAD; #1;
    tests++; if ({a.mem_req_valid, a.ifu_resp_valid, a.lsu_resp_valid, a.ifu_resp_err, a.lsu_resp_err, a.ifu_req_ready, a.lsu_req_ready} !== 7'b0) begin fails++; $display("FAIL rm_flags got %b exp 0000000", {a.mem_req_valid, a.ifu_resp_valid, a.lsu_resp_valid, a.ifu_resp_err, a.lsu_resp_err, a.ifu_req_ready, a.lsu_req_ready}); end
    tests++; if ({a.mem_req_addr, a.ifu_resp_data} !== 64'h0) begin fails++; $display("FAIL rm_data got %h exp 0", {a.mem_req_addr, a.ifu_resp_data}); end
    cyc(); a.mem_resp_valid = 0; #1;
    tests++; if (a.ifu_resp_valid !== 1'b0) begin fails++; $display("FAIL rm_no_resp got %b exp 0", a.ifu_resp_valid); end
    cyc(); a.ifu_req_valid = 1; a.ifu_req_addr = 32'h20; #1;
    tests++; if (a.ifu_req_ready !== 1'b1) begin fails++; $display("FAIL rm_accept got %b exp 1", a.ifu_req_ready); end
    cyc(); a.ifu_req_valid = 0; #1;
    tests++; if (a.mem_req_addr !== 32'h20) begin fails++; $display("FAIL rm_addr got %h exp 00000020", a.mem_req_addr); end
    cyc(); a.mem_resp_valid = 1; a.mem_resp_rdata = 32'h99; #1;
    cyc(); a.mem_resp_valid = 0; #1;
    tests++; if ({a.ifu_resp_valid, a.ifu_resp_err, a.ifu_resp_data} !== {1'b1, 1'b0, 32'h99}) begin fails++; $display("FAIL rm_resp got %h exp %h", {a.ifu_resp_valid, a.ifu_resp_err, a.ifu_resp_data}, {1'b1, 1'b0, 32'h99}); end
    cyc(); #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    init_inputs();
    test_reset();
    test_ifu_fetch();
    test_arbitration();
    test_store_stall();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
